// File: rtl/hqm_iosf_handshake_arb.sv
// hqm_iosf_handshake_arb
// Round-robin arbiter that shares one single-entry val/rdy CDC handshake
// channel among NUM_REQ source-domain requesters. The granted requester's
// data is captured at grant and held until the channel's rdy_src pulse.
// A one-cycle GAP after each completion forces a val_src falling edge.
// Optional feature: define HQM_IOSF_HS_ARB_TIMEOUT_EN to enable the sticky
// err_timeout flag for REQ phases that last TIMEOUT_CYC cycles.
module hqm_iosf_handshake_arb #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 1024,
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_src,
    input  logic                     rst_src_n,
    input  logic [NUM_REQ-1:0]       req_val,
    input  logic [NUM_REQ*WIDTH-1:0] req_dat,
    output logic [NUM_REQ-1:0]       req_rdy,
    output logic                     val_src,
    output logic [WIDTH-1:0]         dat_src,
    input  logic                     rdy_src,
    output logic                     busy,
    output logic [GW-1:0]            gnt_id,
    output logic                     err_spurious,
    output logic                     err_timeout
);

    if (NUM_REQ < 1 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("hqm_iosf_handshake_arb: NUM_REQ must be 1..16 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     rr_ptr;
    logic              pick_vld;
    logic [GW-1:0]     pick;
    logic              hi_vld;
    logic [GW-1:0]     hi_pick;
    logic [GW-1:0]     lo_pick;
    logic [WIDTH-1:0]  pick_dat;

    // Round-robin scan: lowest requester at/above rr_ptr wins, else lowest overall (wrap)
    always_comb begin
        pick_vld = 1'b0;
        hi_vld   = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_val[j]) begin
                pick_vld = 1'b1;
                lo_pick  = GW'(j);
                if (j >= int'(rr_ptr)) begin
                    hi_vld  = 1'b1;
                    hi_pick = GW'(j);
                end
            end
        end
        pick = hi_vld ? hi_pick : lo_pick;
    end

    // Data mux for the requester chosen by the scan
    always_comb begin
        pick_dat = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == GW'(j)) begin
                pick_dat = req_dat[j*WIDTH +: WIDTH];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and same-cycle accept pulse to the granted requester
    always_comb begin
        state_nxt = state;
        req_rdy   = '0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (rdy_src) begin
                    state_nxt = GAP;
                    for (int j = 0; j < NUM_REQ; j++) begin
                        req_rdy[j] = (gnt_id == GW'(j));
                    end
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant capture, registered channel valid, rr pointer advance, spurious flag
    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            val_src      <= 1'b0;
            dat_src      <= '0;
            gnt_id       <= '0;
            rr_ptr       <= '0;
            err_spurious <= 1'b0;
        end else begin
            val_src <= (state_nxt == REQ);
            if (state == IDLE && pick_vld) begin
                gnt_id  <= pick;
                dat_src <= pick_dat;
            end
            if (state == REQ && rdy_src) begin
                rr_ptr <= (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + GW'(1);
            end
            if (state != REQ && rdy_src) begin
                err_spurious <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef HQM_IOSF_HS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] to_cnt;
    logic          to_err;

    // REQ-phase length counter (cleared before entry, saturating) and sticky timeout flag;
    // the transfer itself is never aborted since the CDC channel owns it
    always_ff @(posedge clk_src or negedge rst_src_n) begin
        if (!rst_src_n) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if (state == REQ && to_cnt != CW'(TIMEOUT_CYC)) begin
                to_cnt <= to_cnt + CW'(1);
            end
            if (state == REQ && !rdy_src && to_cnt == CW'(TIMEOUT_CYC - 1)) begin
                to_err <= 1'b1;
            end
        end
    end

    assign err_timeout = to_err;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_iosf_handshake_arb.sv
// Scoreboard bench for hqm_iosf_handshake_arb (NUM_REQ=4, WIDTH=32, TIMEOUT_CYC=16).
module tb_hqm_iosf_handshake_arb;

`ifdef HQM_IOSF_HS_ARB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic         clk_src = 1'b0;
    logic         rst_src_n = 1'b0;
    logic [3:0]   req_val = '0;
    logic [127:0] req_dat = '0;
    logic [3:0]   req_rdy;
    logic         val_src;
    logic [31:0]  dat_src;
    logic         rdy_src = 1'b0;
    logic         busy;
    logic [1:0]   gnt_id;
    logic         err_spurious;
    logic         err_timeout;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] dat;
    } txn_t;

    txn_t       exp_txn[$];
    logic [3:0] exp_rdy[$];

    hqm_iosf_handshake_arb #(
        .NUM_REQ(4),
        .WIDTH(32),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk_src(clk_src),
        .rst_src_n(rst_src_n),
        .req_val(req_val),
        .req_dat(req_dat),
        .req_rdy(req_rdy),
        .val_src(val_src),
        .dat_src(dat_src),
        .rdy_src(rdy_src),
        .busy(busy),
        .gnt_id(gnt_id),
        .err_spurious(err_spurious),
        .err_timeout(err_timeout)
    );

    always #5 clk_src = ~clk_src;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic push(input logic [1:0] g, input logic [31:0] d, input logic [3:0] r);
        txn_t t;
        t.gnt = g;
        t.dat = d;
        exp_txn.push_back(t);
        exp_rdy.push_back(r);
    endtask

    // Wait for val_src, optionally churn a requester's data, complete, check GAP/IDLE timing
    task automatic serve(input int delay, input logic [3:0] drop, input int churn);
        int n;
        n = 0;
        while (!val_src && n < 50) begin
            tick();
            n++;
        end
        if (!val_src) begin
            checks++;
            failures++;
            $display("FAIL serve_wait: val_src not seen within %0d cycles", n);
            return;
        end
        for (int k = 0; k < delay; k++) begin
            if (churn >= 0) req_dat[churn*32 +: 32] = 32'hBBBB_0000 + k;
            tick();
        end
        rdy_src = 1'b1;
        tick();
        rdy_src = 1'b0;
        req_val = req_val & ~drop;
        chk("gap_val_low", {31'd0, val_src}, 32'd0);
        chk("gap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_val_src"}, {31'd0, val_src}, 32'd0);
        chk({tag, "_dat_src"}, dat_src, 32'd0);
        chk({tag, "_req_rdy"}, {28'd0, req_rdy}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_gnt_id"}, {30'd0, gnt_id}, 32'd0);
        chk({tag, "_err_spurious"}, {31'd0, err_spurious}, 32'd0);
        chk({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
    endtask

    // Monitor: pop expectations on each val_src rise and each req_rdy pulse
    logic        val_q = 1'b0;
    logic [31:0] hold_dat = '0;
    always @(negedge clk_src) begin
        txn_t t;
        logic [3:0] r;
        if (!rst_src_n) begin
            val_q = 1'b0;
        end else begin
            if (val_src && !val_q) begin
                if (exp_txn.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant: gnt_id=%0d dat_src=%h", gnt_id, dat_src);
                end else begin
                    t = exp_txn.pop_front();
                    chk("grant_id", {30'd0, gnt_id}, {30'd0, t.gnt});
                    chk("grant_dat", dat_src, t.dat);
                    hold_dat = t.dat;
                end
            end else if (val_src) begin
                chk("dat_hold", dat_src, hold_dat);
            end
            if (req_rdy != 4'b0000) begin
                if (exp_rdy.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req_rdy: got %b", req_rdy);
                end else begin
                    r = exp_rdy.pop_front();
                    chk("req_rdy", {28'd0, req_rdy}, {28'd0, r});
                end
            end
            val_q = val_src;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values
        repeat (3) tick();
        check_reset_vals("reset");
        rst_src_n = 1'b1;
        tick();

        // Single request with latency checks
        req_dat[1*32 +: 32] = 32'hCAFE_0001;
        push(2'd1, 32'hCAFE_0001, 4'b0010);
        req_val = 4'b0010;
        tick();
        chk("single_val_lat", {31'd0, val_src}, 32'd1);
        chk("single_gnt", {30'd0, gnt_id}, 32'd1);
        serve(3, 4'b0010, -1);

        // Mid-operation reset: grant seen, then reset while in REQ
        req_dat[3*32 +: 32] = 32'hDEAD_0003;
        exp_txn.push_back('{gnt: 2'd3, dat: 32'hDEAD_0003});
        req_val = 4'b1000;
        tick();
        tick();
        rst_src_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        req_val = 4'b0000;
        tick();
        rst_src_n = 1'b1;
        tick();

        // Round robin with all requesters held high
        for (int i = 0; i < 4; i++) req_dat[i*32 +: 32] = 32'h1000_0000 + i;
        push(2'd0, 32'h1000_0000, 4'b0001);
        push(2'd1, 32'h1000_0001, 4'b0010);
        push(2'd2, 32'h1000_0002, 4'b0100);
        push(2'd3, 32'h1000_0003, 4'b1000);
        push(2'd0, 32'h1000_0000, 4'b0001);
        req_val = 4'b1111;
        for (int i = 0; i < 4; i++) serve(5, 4'b0000, -1);
        serve(5, 4'b1111, -1);

        // Wrap and skip: move rr pointer to 3 via requester 2, then 0101 -> 0 then 2
        push(2'd2, 32'h1000_0002, 4'b0100);
        req_val = 4'b0100;
        serve(2, 4'b0100, -1);
        push(2'd0, 32'h1000_0000, 4'b0001);
        push(2'd2, 32'h1000_0002, 4'b0100);
        req_val = 4'b0101;
        serve(2, 4'b0001, -1);
        serve(2, 4'b0100, -1);

        // Data stability: requester 1 changes its data every REQ cycle
        req_dat[1*32 +: 32] = 32'hAAAA_0000;
        push(2'd1, 32'hAAAA_0000, 4'b0010);
        req_val = 4'b0010;
        serve(5, 4'b0010, 1);

        // Spurious completion while IDLE, then a normal request
        rdy_src = 1'b1;
        #1;
        chk("spur_no_rdy", {28'd0, req_rdy}, 32'd0);
        tick();
        rdy_src = 1'b0;
        chk("spur_err", {31'd0, err_spurious}, 32'd1);
        chk("spur_idle", {31'd0, busy}, 32'd0);
        req_dat[3*32 +: 32] = 32'h5555_0003;
        push(2'd3, 32'h5555_0003, 4'b1000);
        req_val = 4'b1000;
        serve(1, 4'b1000, -1);

        // Long REQ phase: err_timeout only with the optional feature
        req_dat[0*32 +: 32] = 32'hD00D_0001;
        push(2'd0, 32'hD00D_0001, 4'b0001);
        req_val = 4'b0001;
        n = 0;
        tick();
        while (!val_src && n < 20) begin
            tick();
            n++;
        end
        repeat (15) tick();
        chk("to_early", {31'd0, err_timeout}, 32'd0);
        tick();
        chk("to_set", {31'd0, err_timeout}, {31'd0, TO_EN});
        chk("to_val_held", {31'd0, val_src}, 32'd1);
        serve(0, 4'b0001, -1);
        chk("to_sticky", {31'd0, err_timeout}, {31'd0, TO_EN});
        chk("spur_sticky", {31'd0, err_spurious}, 32'd1);

        // Sticky errors clear only on reset
        rst_src_n = 1'b0;
        #1;
        check_reset_vals("final_reset");
        tick();

        chk("txn_queue_empty", exp_txn.size(), 32'd0);
        chk("rdy_queue_empty", exp_rdy.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
